// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - one-write, two-read register file with zero entry and write-to-read bypass
// Async active-low clear; reads are combinational and may forward the in-flight write.
module regfile_bypass #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = 31,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2
);

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_IDX);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_hit;
  logic             wr_zero;
  logic             wr_ok;

  // Matching against the real entry list doubles as the range check for non-power-of-two depths.
  always_comb begin
    wr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == AW'(i)) wr_hit = 1'b1;
    end
  end

  assign wr_zero = (ZERO_EN != 0) && (wr_addr == ZIDX);
  assign wr_ok   = rst && wr_en && wr_hit && !wr_zero;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (wr_addr == AW'(i))) mem_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] data;
    logic             hit;
    logic             zero;

    assign addr = (p == 0) ? rd_addr1 : rd_addr2;
    assign zero = (ZERO_EN != 0) && (addr == ZIDX);

    always_comb begin
      stored = '0;
      hit    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr == AW'(i)) begin
          stored = mem_q[i];
          hit    = 1'b1;
        end
      end
    end

    // Priority: reset, then zero/out-of-range, then forwarded write, then storage.
    always_comb begin
      data = '0;
      if (!rst || !hit || zero) begin
        data = '0;
      end else if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) begin
        data = wr_data;
      end else begin
        data = stored;
      end
    end
  end

  assign rd_data1 = g_rd[0].data;
  assign rd_data2 = g_rd[1].data;

endmodule

// File: tb/tb_regfile_bypass.sv
// tb/tb_regfile_bypass.sv - directed self-checking bench for regfile_bypass
// Main instance uses defaults; a second instance covers DEPTH=20 with no bypass.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic [63:0] rd_data1;
  logic [63:0] rd_data2;

  logic        np_wr_en = 1'b0;
  logic [4:0]  np_wr_addr = '0;
  logic [63:0] np_wr_data = '0;
  logic [4:0]  np_rd_addr1 = '0;
  logic [4:0]  np_rd_addr2 = '0;
  logic [63:0] np_rd_data1;
  logic [63:0] np_rd_data2;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] PAT = 64'h0101_0101_0101_0101;

  always #5 clk = ~clk;

  regfile_bypass dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2)
  );

  regfile_bypass #(.DEPTH(20), .AW(5), .ZERO_IDX(19), .BYPASS(0)) dut_np (
    .clk(clk), .rst(rst),
    .wr_en(np_wr_en), .wr_addr(np_wr_addr), .wr_data(np_wr_data),
    .rd_addr1(np_rd_addr1), .rd_data1(np_rd_data1),
    .rd_addr2(np_rd_addr2), .rd_data2(np_rd_data2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic np_wr(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    np_wr_en = 1'b1; np_wr_addr = a; np_wr_data = d;
    @(posedge clk);
    #1 np_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    rd_addr1 = a1; rd_addr2 = a2;
    #1;
  endtask

  task automatic np_rd(input logic [4:0] a1, input logic [4:0] a2);
    np_rd_addr1 = a1; np_rd_addr2 = a2;
    #1;
  endtask

  initial begin
    // Reset: outputs zero, writes blocked.
    @(negedge clk);
    rd(5'd0, 5'd5);
    check("rst_rd1", rd_data1, 64'h0);
    check("rst_rd2", rd_data2, 64'h0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234; rd(5'd5, 5'd5);
    check("rst_nobypass", rd_data1, 64'h0);
    @(posedge clk); #1;
    check("rst_wrblocked", rd_data2, 64'h0);
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b1;

    // Mid-cycle reset after loading mem[5].
    wr(5'd5, 64'hDEAD);
    rd(5'd5, 5'd5);
    check("load5", rd_data1, 64'hDEAD);
    @(negedge clk);
    #2 wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hBEEF; rst = 1'b0;
    #1 check("async_clear", rd_data1, 64'h0);
    @(posedge clk); #1;
    check("rst_wrlost", rd_data1, 64'h0);
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("rel_stays0", rd_data1, 64'h0);

    // Write every entry, read mirrored pairs.
    for (int i = 0; i < 31; i++) wr(5'(i), 64'(i) * PAT);
    @(negedge clk);
    for (int i = 0; i < 31; i++) begin
      rd(5'(i), 5'(30 - i));
      check("all_rd1", rd_data1, 64'(i) * PAT);
      check("all_rd2", rd_data2, 64'(30 - i) * PAT);
    end
    rd(5'd31, 5'd31);
    check("xzr_rd1", rd_data1, 64'h0);
    check("xzr_rd2", rd_data2, 64'h0);

    // Zero register ignores writes and beats the bypass.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1; rd(5'd31, 5'd30);
    check("xzr_samecyc", rd_data1, 64'h0);
    check("xzr_other", rd_data2, 64'd30 * PAT);
    @(posedge clk); #1 wr_en = 1'b0;
    check("xzr_after", rd_data1, 64'h0);

    // Bypass on both ports.
    wr(5'd7, 64'h11);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h22; rd(5'd7, 5'd7);
    check("byp_rd1", rd_data1, 64'h22);
    check("byp_rd2", rd_data2, 64'h22);
    rd(5'd7, 5'd8);
    check("byp_miss", rd_data2, 64'd8 * PAT);
    @(posedge clk); #1 wr_en = 1'b0;
    rd(5'd7, 5'd7);
    check("byp_after", rd_data1, 64'h22);

    // Write disable for four cycles.
    wr(5'd3, 64'hAA);
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd3; wr_data = 64'h55; rd(5'd4, 5'd3);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("wdis_rd2", rd_data2, 64'hAA);
    end
    check("wdis_other4", rd_data1, 64'd4 * PAT);
    rd(5'd2, 5'd7);
    check("wdis_other2", rd_data1, 64'd2 * PAT);
    check("wdis_other7", rd_data2, 64'h22);

    // DEPTH=20, BYPASS=0 instance.
    for (int i = 0; i < 20; i++) np_wr(5'(i), 64'h100 + 64'(i));
    @(negedge clk);
    np_wr_en = 1'b1; np_wr_addr = 5'd25; np_wr_data = 64'h99; np_rd(5'd25, 5'd19);
    check("np_oor_samecyc", np_rd_data1, 64'h0);
    check("np_zero", np_rd_data2, 64'h0);
    @(posedge clk); #1 np_wr_en = 1'b0;
    np_rd(5'd25, 5'd20);
    check("np_oor_rd", np_rd_data1, 64'h0);
    check("np_oor_rd20", np_rd_data2, 64'h0);
    for (int i = 0; i < 19; i++) begin
      np_rd(5'(i), 5'(18 - i));
      check("np_keep", np_rd_data1, 64'h100 + 64'(i));
    end
    np_wr(5'd7, 64'h11);
    @(negedge clk);
    np_wr_en = 1'b1; np_wr_addr = 5'd7; np_wr_data = 64'h22; np_rd(5'd7, 5'd7);
    check("nobyp_before1", np_rd_data1, 64'h11);
    check("nobyp_before2", np_rd_data2, 64'h11);
    @(posedge clk); #1 np_wr_en = 1'b0;
    check("nobyp_after1", np_rd_data1, 64'h22);
    check("nobyp_after2", np_rd_data2, 64'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised multi-port register file built from write-enabled registers.
- Generalises the fixed 64-bit single register to DEPTH entries of WIDTH bits, with one write port and two read ports.
- Adds a hard-wired zero register, optional write-to-read bypass and address range checking.
- Sits in the decode stage of the pipelined ARM CPU. The ID stage reads operands through it; the WB stage writes results through it.

Parameters:
- WIDTH, 64, data width of each entry in bits (>=1).
- DEPTH, 32, number of entries (2..256); need not be a power of two.
- AW, $clog2(DEPTH), address width in bits.
- ZERO_EN, 1, when 1, entry ZERO_IDX always reads 0 and ignores writes.
- ZERO_IDX, 31, index of the hard-wired zero entry (XZR); must be < DEPTH.
- BYPASS, 1, when 1, a same-cycle write is forwarded to the matching read port.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset; clears all entries while low
- wr_en  input  1  write enable
- wr_addr  input  AW  write index
- wr_data  input  WIDTH  write data
- rd_addr1  input  AW  read port 1 index
- rd_data1  output  WIDTH  read port 1 data
- rd_addr2  input  AW  read port 2 index
- rd_data2  output  WIDTH  read port 2 data

Behaviour:
- Storage: DEPTH x WIDTH flops. Reset is asynchronous and active-low.
  - rst low forces every entry to 0 immediately, independent of clk.
  - Writes are blocked while rst is low.
  - Release is synchronous to the next rising edge; the first write can land on the first rising edge with rst high.
- Reset value of outputs: rd_data1 and rd_data2 read 0 for every address while rst is low.
  - With BYPASS=1, the bypass is suppressed during reset.
- Write: on a rising clk edge, if rst is high, wr_en=1, wr_addr<DEPTH and the target is not the zero entry, then mem[wr_addr] <= wr_data.
  - Otherwise there is no state change. Unaddressed entries always hold.
- Read: combinational, zero-cycle latency, both ports independent. The same address on both ports returns the same value.
- Zero register: when ZERO_EN=1, a read of ZERO_IDX returns 0 and a write to ZERO_IDX is dropped. The zero rule overrides the bypass.
- Out of range: when DEPTH is not a power of two, wr_addr>=DEPTH is a dropped write and rd_addr>=DEPTH reads 0.
- Bypass (BYPASS=1): if wr_en=1, rst=1, wr_addr==rd_addrN, wr_addr is in range and is not the zero entry, then rd_dataN = wr_data in the same cycle.
  - This removes the WB->ID hazard.
  - With BYPASS=0, the read returns the old value until after the edge.
- Read priority per port, highest first:
  1. reset
  2. zero or out-of-range
  3. bypass hit
  4. stored value
- Simultaneous events: a write and two reads to the same address in one cycle means both ports bypass the new value and the entry updates at the edge.
- Reset asserted mid-cycle with wr_en=1: the write is lost and the entry stays 0.
- No internal state beyond storage, so there is no FSM. The block is fully synchronous apart from the async clear.

Test Plan:
- Reset: drive rst=0 mid-cycle after loading mem[5]=0xDEAD -> rd_data1 with rd_addr1=5 reads 0 before the next edge; after release it stays 0 until rewritten.
- Write/read all: write mem[i]=i*0x0101_0101_0101_0101 for i=0..30, then read every pair (i, 30-i) -> both ports return the written patterns; mem[31] reads 0.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to addr 31 with rd_addr1=31 in the same cycle -> rd_data1=0 in that cycle and every later cycle.
- Bypass: mem[7]=0x11; write 0x22 to addr 7 with rd_addr1=rd_addr2=7 -> both ports show 0x22 before the edge (BYPASS=1), or 0x11 before and 0x22 after the edge (BYPASS=0).
- Write disable: mem[3]=0xAA, set wr_en=0 with wr_data=0x55 and wr_addr=3 for 4 cycles -> rd_data2 stays 0xAA and no other entry changes.
- Non-power-of-two: DEPTH=20, AW=5; write 0x99 to addr 25 and read addr 25 -> rd_data=0, and entries 0..19 are unchanged.
